// File: rtl/clk_meter_pkg.sv
// Shared types for clock_ratio_meter: FSM state enum and synchroniser depth.
// Depth follows CLK_METER_SYNC_EN (2 sync flops when defined, none otherwise).
package clk_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } meter_state_e;

`ifdef CLK_METER_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif

endpackage

// File: rtl/clk_edge_detect.sv
// Rise/fall strobes from a sampled clock; optional 2-flop synchroniser
// in front of the history flop when CLK_METER_SYNC_EN is defined.
module clk_edge_detect
  import clk_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic rise,
  output logic fall
);

  logic smp;
  logic hist_q;

`ifdef CLK_METER_SYNC_EN
  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_DEPTH-2:0], clk_in};
  end

  assign smp = sync_q[SYNC_DEPTH-1];
`else
  assign smp = clk_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 1'b0;
    else     hist_q <= smp;
  end

  assign rise = smp & ~hist_q;
  assign fall = ~smp & hist_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period / high time of clk_in in clk cycles and flags lock once
// LOCK_CNT consecutive periods match. CLK_METER_SYNC_EN adds input sync.
module clock_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       LOCK_V  = 8'(LOCK_CNT);

  logic             rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_cap_q, ref_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic [7:0]       match_q;
  logic             valid_q, locked_q, ovf_q;
  meter_state_e     state_q;

  clk_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clk_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (rise)                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      high_cap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (fall) high_cap_q <= cnt_q;
    end
  end

  // A rise beats saturation so a period of exactly CNT_MAX still publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ref_q    <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (rise) state_q <= ST_FIRST;
        ST_FIRST, ST_RUN: begin
          if (rise) begin
            period_q <= cnt_q;
            high_q   <= high_cap_q;
            valid_q  <= 1'b1;
            ovf_q    <= 1'b0;
            if (state_q == ST_FIRST) begin
              ref_q   <= cnt_q;
              match_q <= '0;
              state_q <= ST_RUN;
            end else if (cnt_q == ref_q) begin
              if (match_q != LOCK_V) begin
                match_q <= match_q + 8'd1;
                if (match_q + 8'd1 == LOCK_V) locked_q <= 1'b1;
              end
            end else begin
              match_q  <= '0;
              locked_q <= 1'b0;
              ref_q    <= cnt_q;
            end
          end else if (cnt_q == CNT_MAX) begin
            ovf_q    <= 1'b1;
            locked_q <= 1'b0;
            match_q  <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Scoreboard bench for clock_ratio_meter: expected measurements are queued
// as clk_in rising edges are driven and popped on each meas_valid.
module tb_clock_ratio_meter;

  localparam int CNT_W = 8;
  localparam int LOCK  = 4;
`ifdef CLK_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int per;
    int hi;
    bit lk;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, locked, overflow;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  // reference model state
  int nr = 0, prev_hi = 0, prev_lo = 0, ref_p = 0, match = 0;
  bit mlock = 1'b0;

  clock_ratio_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_meas_valid cyc=%0d period=%0d high=%0d", cyc, period, high_time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 5;
        if (period !== CNT_W'(e.per)) begin
          errors++; $display("FAIL period got=%0d exp=%0d cyc=%0d", period, e.per, cyc);
        end
        if (high_time !== CNT_W'(e.hi)) begin
          errors++; $display("FAIL high_time got=%0d exp=%0d cyc=%0d", high_time, e.hi, cyc);
        end
        if (locked !== e.lk) begin
          errors++; $display("FAIL locked_at_meas got=%0b exp=%0b cyc=%0d", locked, e.lk, cyc);
        end
        if (overflow !== 1'b0) begin
          errors++; $display("FAIL overflow_at_meas got=%0b exp=0 cyc=%0d", overflow, cyc);
        end
        if (cyc != e.cyc) begin
          errors++; $display("FAIL meas_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic model_clear();
    nr = 0; match = 0; mlock = 1'b0;
  endtask

  task automatic model_rise(input int c);
    exp_t e;
    int   per;
    if (nr >= 1) begin
      per = prev_hi + prev_lo;
      if (nr == 1) begin
        ref_p = per; match = 0;
      end else if (per == ref_p) begin
        if (match < LOCK) match++;
        if (match == LOCK) mlock = 1'b1;
      end else begin
        match = 0; mlock = 1'b0; ref_p = per;
      end
      e.per = per; e.hi = prev_hi; e.lk = mlock; e.cyc = c + LAT;
      sb.push_back(e);
    end
    nr++;
  endtask

  task automatic drive_period(input int hi, input int lo);
    for (int i = 0; i < hi + lo; i++) begin
      @(posedge clk); #1;
      clk_in = (i < hi);
      if (i == 0) begin
        model_rise(cyc);
        prev_hi = hi; prev_lo = lo;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_in = 1'b0;
    idle_cycles(3);
    checks += 5;
    if (period !== '0)     begin errors++; $display("FAIL reset_period got=%0d exp=0", period); end
    if (high_time !== '0)  begin errors++; $display("FAIL reset_high got=%0d exp=0", high_time); end
    if (meas_valid !== 0)  begin errors++; $display("FAIL reset_valid got=%0b exp=0", meas_valid); end
    if (locked !== 0)      begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    if (overflow !== 0)    begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    rst = 1'b0;
    model_clear();
    idle_cycles(3);
  endtask

  task automatic test_div6_lock();
    for (int k = 0; k < 7; k++) drive_period(3, 3);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL div6_locked got=%0b exp=1", locked); end
  endtask

  task automatic test_div2_div5();
    for (int k = 0; k < 4; k++) drive_period(1, 1);
    for (int k = 0; k < 6; k++) drive_period(2, 3);
  endtask

  task automatic test_relock();
    for (int k = 0; k < 6; k++) drive_period(3, 3);
    for (int k = 0; k < 7; k++) drive_period(5, 5);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock got=%0b exp=1", locked); end
  endtask

  task automatic test_overflow();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) drive_period(3, 3);
    @(posedge clk); #1;
    clk_in = 1'b1;
    model_rise(cyc);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (overflow === 1'b1) seen = 1'b1;
    end
    checks += 4;
    if (!seen)              begin errors++; $display("FAIL overflow_timeout got=%0b exp=1", overflow); end
    if (locked !== 1'b0)    begin errors++; $display("FAIL ovf_locked got=%0b exp=0", locked); end
    if (period !== 8'd6)    begin errors++; $display("FAIL ovf_period_hold got=%0d exp=6", period); end
    if (high_time !== 8'd3) begin errors++; $display("FAIL ovf_high_hold got=%0d exp=3", high_time); end
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; clk_in = 1'b0;
    end
    for (int k = 0; k < 3; k++) drive_period(3, 3);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) drive_period(3, 3);
    drive_period(3, 2);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_locked got=%0b exp=1", locked); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (period !== '0)    begin errors++; $display("FAIL rst_mid_period got=%0d exp=0", period); end
    if (high_time !== '0) begin errors++; $display("FAIL rst_mid_high got=%0d exp=0", high_time); end
    if (meas_valid !== 0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", meas_valid); end
    if (locked !== 0)     begin errors++; $display("FAIL rst_mid_locked got=%0b exp=0", locked); end
    if (overflow !== 0)   begin errors++; $display("FAIL rst_mid_overflow got=%0b exp=0", overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rst_pending got=%0d exp=0", sb.size()); end
    sb.delete();
    idle_cycles(2);
    for (int k = 0; k < 4; k++) drive_period(3, 3);
  endtask

  initial begin
    test_reset();
    test_div6_lock();
    test_div2_div5();
    test_relock();
    test_overflow();
    test_reset_mid();
    idle_cycles(LAT + 3);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL missing_meas_valid got_left=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
